// File: rtl/road_script_sequencer.sv
// road_script_sequencer: scripted road-edge generator, one row per request.
// Walks a fixed 4-segment bend script; difficulty sharpens and shortens bends.
// Ports: clk, rst (async high), restart (sync re-init), row_req (pulse in),
//   row_ack (pulse out, edges valid), left_edge/right_edge (10b columns),
//   level (4b), row_count (16b, saturating), seg_idx (2b), overrun (sticky).
// Optional feature: define ROAD_CLAMP_EN to reflect the road at XMIN/XMAX.
module road_script_sequencer #(
  parameter int XCENTER        = 464,
  parameter int HALF_ROAD      = 50,
  parameter int ROWS_PER_LEVEL = 56,
  parameter int MAX_LEVEL      = 8,
  parameter int XMIN           = 194,
  parameter int XMAX           = 733
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic        row_req,
  output logic        row_ack,
  output logic [9:0]  left_edge,
  output logic [9:0]  right_edge,
  output logic [3:0]  level,
  output logic [15:0] row_count,
  output logic [1:0]  seg_idx,
  output logic        overrun
);

  typedef enum logic {
    S_LOAD,
    S_RUN
  } state_t;

  localparam logic signed [10:0] CTR0 =
    11'(XCENTER);
  localparam logic [9:0] HALF10 =
    10'(HALF_ROAD);
  localparam logic [9:0] LEFT0 =
    10'(XCENTER - HALF_ROAD);
  localparam logic [9:0] RIGHT0 =
    10'(XCENTER + HALF_ROAD);
  localparam logic [5:0] LVL_WRAP =
    6'(ROWS_PER_LEVEL - 1);
  localparam logic [3:0] LVL_MAX =
    4'(MAX_LEVEL);

`ifdef ROAD_CLAMP_EN
  localparam logic signed [10:0] XMIN_S =
    11'(XMIN);
  localparam logic signed [10:0] XMAX_S =
    11'(XMAX);
`else
  logic unused_lim;
  assign unused_lim = (XMIN < XMAX);
`endif

  state_t             state_q;
  logic [1:0]         ptr_q;
  logic               pending_q;
  logic signed [10:0] centre_q;
  logic signed [5:0]  delta_q;
  logic [8:0]         rows_q;
  logic [5:0]         lvl_cnt_q;
  logic [3:0]         level_q;
  logic [15:0]        count_q;
  logic [1:0]         seg_q;
  logic [9:0]         left_q;
  logic [9:0]         right_q;
  logic               ack_q;
  logic               ovr_q;

  logic signed [5:0]  scr_d;
  logic [8:0]         scr_r;
  logic signed [5:0]  lvl_s;
  logic [8:0]         lvl2;
  logic signed [5:0]  ld_delta;
  logic [8:0]         ld_rows;
  logic signed [5:0]  cur_delta;
  logic [8:0]         cur_rows;
  logic signed [10:0] sum;
  logic signed [10:0] centre_d;
  logic signed [5:0]  delta_d;
  logic [9:0]         left_d;
  logic [9:0]         right_d;
  logic               emit;
  logic               advance;

  always_comb begin
    scr_d = 6'sd0;
    scr_r = 9'd10;
    case (ptr_q)
      2'd0: begin
        scr_d = 6'sd0;
        scr_r = 9'd10;
      end
      2'd1: begin
        scr_d = 6'sd3;
        scr_r = 9'd18;
      end
      2'd2: begin
        scr_d = 6'sd0;
        scr_r = 9'd10;
      end
      default: begin
        scr_d = -6'sd3;
        scr_r = 9'd18;
      end
    endcase
  end

  always_comb begin
    lvl_s = $signed({2'b00, level_q});
    lvl2  = {4'b0000, level_q, 1'b0};
    if (scr_d > 6'sd0) begin
      ld_delta = scr_d + lvl_s;
    end else if (scr_d < 6'sd0) begin
      ld_delta = scr_d - lvl_s;
    end else begin
      ld_delta = 6'sd0;
    end
    if (scr_r > lvl2) begin
      ld_rows = scr_r - lvl2;
    end else begin
      ld_rows = 9'd1;
    end
  end

  // A pending request that meets a segment boundary is served straight
  // out of S_LOAD with the freshly loaded delta, so a boundary costs
  // exactly one extra cycle.
  always_comb begin
    if (state_q == S_LOAD) begin
      cur_delta = ld_delta;
      cur_rows  = ld_rows;
    end else begin
      cur_delta = delta_q;
      cur_rows  = rows_q;
    end
    emit    = pending_q && (cur_rows != 9'd0);
    advance = pending_q
           && (state_q == S_RUN)
           && (rows_q == 9'd0);
    left_d  = centre_q[9:0] - HALF10;
    right_d = centre_q[9:0] + HALF10;
  end

  always_comb begin
    sum = centre_q
        + {{5{cur_delta[5]}}, cur_delta};
    centre_d = sum;
    delta_d  = cur_delta;
`ifdef ROAD_CLAMP_EN
    // Reflect off the limits: pin the centre
    // and bend back for the rest of the segment.
    if (sum < XMIN_S) begin
      centre_d = XMIN_S;
      delta_d  = -cur_delta;
    end else if (sum > XMAX_S) begin
      centre_d = XMAX_S;
      delta_d  = -cur_delta;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_LOAD;
      ptr_q     <= 2'd0;
      pending_q <= 1'b0;
      centre_q  <= CTR0;
      delta_q   <= 6'sd0;
      rows_q    <= 9'd0;
      lvl_cnt_q <= 6'd0;
      level_q   <= 4'd1;
      count_q   <= 16'd0;
      seg_q     <= 2'd0;
      left_q    <= LEFT0;
      right_q   <= RIGHT0;
      ack_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else if (restart) begin
      state_q   <= S_LOAD;
      ptr_q     <= 2'd0;
      pending_q <= 1'b0;
      centre_q  <= CTR0;
      delta_q   <= 6'sd0;
      rows_q    <= 9'd0;
      lvl_cnt_q <= 6'd0;
      level_q   <= 4'd1;
      count_q   <= 16'd0;
      seg_q     <= 2'd0;
      left_q    <= LEFT0;
      right_q   <= RIGHT0;
      ack_q     <= 1'b0;
    end else begin
      ack_q     <= 1'b0;
      pending_q <= (pending_q && !emit)
                || (row_req && !pending_q);
      if (row_req && pending_q) begin
        ovr_q <= 1'b1;
      end

      if (emit) begin
        ack_q    <= 1'b1;
        left_q   <= left_d;
        right_q  <= right_d;
        centre_q <= centre_d;
        delta_q  <= delta_d;
        rows_q   <= cur_rows - 9'd1;
        if (count_q != 16'hFFFF) begin
          count_q <= count_q + 16'd1;
        end
        if (lvl_cnt_q == LVL_WRAP) begin
          lvl_cnt_q <= 6'd0;
          if (level_q < LVL_MAX) begin
            level_q <= level_q + 4'd1;
          end
        end else begin
          lvl_cnt_q <= lvl_cnt_q + 6'd1;
        end
      end else if (state_q == S_LOAD) begin
        delta_q <= ld_delta;
        rows_q  <= ld_rows;
      end

      unique case (state_q)
        S_LOAD: begin
          seg_q   <= ptr_q;
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (advance) begin
            ptr_q   <= ptr_q + 2'd1;
            state_q <= S_LOAD;
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign row_ack    = ack_q;
  assign left_edge  = left_q;
  assign right_edge = right_q;
  assign level      = level_q;
  assign row_count  = count_q;
  assign seg_idx    = seg_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_road_script_sequencer.sv
// tb_road_script_sequencer: scoreboard bench for road_script_sequencer.
// Expected rows come from a small behavioural road model.
module tb_road_script_sequencer;

  localparam int XMIN_TB = 194;
  localparam int XMAX_TB = 470;

  logic        clk = 1'b0;
  logic        rst;
  logic        restart;
  logic        row_req;
  logic        row_ack;
  logic [9:0]  left_edge;
  logic [9:0]  right_edge;
  logic [3:0]  level;
  logic [15:0] row_count;
  logic [1:0]  seg_idx;
  logic        overrun;

  always #5 clk = ~clk;

  road_script_sequencer #(
    .XMAX(XMAX_TB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .restart   (restart),
    .row_req   (row_req),
    .row_ack   (row_ack),
    .left_edge (left_edge),
    .right_edge(right_edge),
    .level     (level),
    .row_count (row_count),
    .seg_idx   (seg_idx),
    .overrun   (overrun)
  );

  typedef struct {
    int left;
    int right;
    int seg;
    int lvl;
    int cnt;
    int lat;
    int req_cyc;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ack_cnt = 0;
  int obs_left, obs_right, obs_seg;
  int obs_lvl, obs_cnt;

  int m_ptr, m_rows, m_centre, m_delta;
  int m_level, m_lcnt, m_count;
  int SD[4] = '{0, 3, 0, -3};
  int SR[4] = '{10, 18, 10, 18};

  task automatic chk(input string tag,
                     input int got,
                     input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic mdl_load();
    int d;
    int r;
    d = SD[m_ptr];
    r = SR[m_ptr];
    if (d > 0) m_delta = d + m_level;
    else if (d < 0) m_delta = d - m_level;
    else m_delta = 0;
    m_rows = (r > 2 * m_level) ? r - 2 * m_level : 1;
  endtask

  task automatic mdl_reset();
    m_ptr    = 0;
    m_centre = 464;
    m_level  = 1;
    m_lcnt   = 0;
    m_count  = 0;
    mdl_load();
  endtask

  task automatic mdl_row(output exp_t e);
    int s;
    e.lat = 1;
    if (m_rows == 0) begin
      m_ptr = (m_ptr + 1) % 4;
      mdl_load();
      e.lat = 2;
    end
    e.left  = (m_centre - 50) & 1023;
    e.right = (m_centre + 50) & 1023;
    e.seg   = m_ptr;
    s = m_centre + m_delta;
`ifdef ROAD_CLAMP_EN
    if (s < XMIN_TB) begin
      s = XMIN_TB;
      m_delta = -m_delta;
    end else if (s > XMAX_TB) begin
      s = XMAX_TB;
      m_delta = -m_delta;
    end
`endif
    if (s > 1023) s = s - 2048;
    if (s < -1024) s = s + 2048;
    m_centre = s;
    m_rows--;
    if (m_count < 65535) m_count++;
    if (m_lcnt == 55) begin
      m_lcnt = 0;
      if (m_level < 8) m_level++;
    end else begin
      m_lcnt++;
    end
    e.lvl = m_level;
    e.cnt = m_count;
    e.req_cyc = 0;
  endtask

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (row_ack) begin
      exp_t e;
      ack_cnt++;
      obs_left  = int'(left_edge);
      obs_right = int'(right_edge);
      obs_seg   = int'(seg_idx);
      obs_lvl   = int'(level);
      obs_cnt   = int'(row_count);
      chk("ack_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("left", obs_left, e.left);
        chk("right", obs_right, e.right);
        chk("seg", obs_seg, e.seg);
        chk("level", obs_lvl, e.lvl);
        chk("count", obs_cnt, e.cnt);
        chk("latency", cyc - e.req_cyc, e.lat);
      end
    end
  end

  task automatic req();
    exp_t e;
    mdl_row(e);
    @(negedge clk);
    e.req_cyc = cyc + 1;
    sb.push_back(e);
    row_req = 1'b1;
    @(negedge clk);
    row_req = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++)
      @(negedge clk);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int seg1[6];
    int acks;
    rst     = 1'b1;
    restart = 1'b0;
    row_req = 1'b0;
    #1;
    chk("rst_ack", int'(row_ack), 0);
    chk("rst_left", int'(left_edge), 414);
    chk("rst_right", int'(right_edge), 514);
    chk("rst_level", int'(level), 1);
    chk("rst_count", int'(row_count), 0);
    chk("rst_seg", int'(seg_idx), 0);
    chk("rst_ovr", int'(overrun), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mdl_reset();
    repeat (3) @(negedge clk);

    for (int i = 0; i < 8; i++) req();
    chk("s0_left", obs_left, 414);
    req();
    chk("s1_seg", obs_seg, 1);
    chk("s1_left", obs_left, 414);
    req();
    chk("s1_r1_left", obs_left, 418);
    chk("s1_r1_right", obs_right, 518);

    while (m_count < 56) req();
    chk("lvl2", int'(level), 2);
    chk("cnt56", int'(row_count), 56);
    req();
    chk("l2_seg", obs_seg, 1);
`ifdef ROAD_CLAMP_EN
    chk("l2_left", obs_left, 300);
    req();
    chk("l2_d5_left", obs_left, 305);
`else
    chk("l2_left", obs_left, 414);
    req();
    chk("l2_d5_left", obs_left, 419);
`endif

    acks = ack_cnt;
    @(negedge clk);
    restart = 1'b1;
    row_req = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    row_req = 1'b0;
    mdl_reset();
    repeat (5) @(negedge clk);
    chk("rr_ovr", int'(overrun), 0);
    chk("rr_noack", ack_cnt, acks);
    chk("rr_count", int'(row_count), 0);
    chk("rr_left", int'(left_edge), 414);
    chk("rr_level", int'(level), 1);

    for (int i = 0; i < 8; i++) req();
    for (int k = 0; k < 6; k++) begin
      req();
      seg1[k] = obs_left;
    end
    chk("cl_r0", seg1[0], 414);
    chk("cl_r1", seg1[1], 418);
`ifdef ROAD_CLAMP_EN
    chk("cl_r2", seg1[2], 420);
    chk("cl_r3", seg1[3], 416);
    chk("cl_r5", seg1[5], 408);
`else
    chk("cl_r2", seg1[2], 422);
    chk("cl_r3", seg1[3], 426);
    chk("cl_r5", seg1[5], 434);
`endif

    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    mdl_reset();
    repeat (3) @(negedge clk);
    acks = ack_cnt;
    begin
      exp_t e;
      mdl_row(e);
      e.req_cyc = cyc + 1;
      sb.push_back(e);
      row_req = 1'b1;
      repeat (2) @(negedge clk);
      row_req = 1'b0;
      repeat (6) @(negedge clk);
    end
    chk("ovr_one_ack", ack_cnt - acks, 1);
    chk("ovr_set", int'(overrun), 1);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    mdl_reset();
    repeat (3) @(negedge clk);
    chk("ovr_kept", int'(overrun), 1);

    for (int i = 0; i < 10; i++) req();
    acks = ack_cnt;
    row_req = 1'b1;
    @(negedge clk);
    row_req = 1'b0;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    mdl_reset();
    repeat (6) @(negedge clk);
    chk("rp_noack", ack_cnt, acks);
    req();
    chk("rp_left", obs_left, 414);
    chk("rp_right", obs_right, 514);
    chk("rp_level", obs_lvl, 1);
    chk("rp_count", obs_cnt, 1);
    chk("rp_seg", obs_seg, 0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdl_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) req();
    acks = ack_cnt;
    row_req = 1'b1;
    @(negedge clk);
    row_req = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_count", int'(row_count), 0);
    chk("ar_left", int'(left_edge), 414);
    chk("ar_right", int'(right_edge), 514);
    chk("ar_level", int'(level), 1);
    chk("ar_seg", int'(seg_idx), 0);
    chk("ar_ack", int'(row_ack), 0);
    chk("ar_ovr", int'(overrun), 0);
    #1;
    rst = 1'b0;
    mdl_reset();
    repeat (6) @(negedge clk);
    chk("ar_noack", ack_cnt, acks);
    req();
    chk("ar_next_left", obs_left, 414);
    chk("ar_next_cnt", obs_cnt, 1);

    drain();
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
